spi_peripheral: RTL and testbench

// - SPI target end for the in-house spi_controller; sits on the FPGA side facing an external/internal SPI initiator.
// - Mode 3 timing: SCLK idles high; MOSI sampled on rising edge, MISO updated on falling edge; MSB first; fixed word length.
// - Fully oversampled: all SPI pins synchronized into clk; clk must be >= 8x SCLK (controller CLOCK_DIVISION >= 8).

---
 rtl/spi_peripheral_pkg.sv | 15 +
 rtl/spi_sync_bit.sv | 32 +++
 rtl/spi_peripheral.sv | 186 ++++++++++++++++++
 tb/tb_spi_peripheral.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_peripheral_pkg.sv
// Shared types for the SPI target: FSM state encoding and the default word type.
package spi_peripheral_pkg;

    localparam int DEFAULT_WORD_BITS = 8;

    typedef logic [DEFAULT_WORD_BITS-1:0] word_t;

    typedef enum logic [1:0] {
        WAIT_DESEL,
        IDLE,
        SHIFT,
        DONE
    } state_t;

endpackage

// File: rtl/spi_sync_bit.sv
// Multi-flop synchronizer for one asynchronous input bit.
// The reset value lets idle-high pins (cs_n, sclk) come out of reset deasserted.
module spi_sync_bit #(
    parameter int   STAGES      = 2,
    parameter logic RESET_VALUE = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
            logic stage_reg;
            if (gi == 0) begin : g_first
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) stage_reg <= RESET_VALUE;
                    else        stage_reg <= d;
                end
            end else begin : g_chain
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) stage_reg <= RESET_VALUE;
                    else        stage_reg <= g_stage[gi-1].stage_reg;
                end
            end
        end
    endgenerate

    assign q = g_stage[STAGES-1].stage_reg;

endmodule

// File: rtl/spi_peripheral.sv
// Oversampled mode-3 SPI target with a one-word TX holding register.
// Define SPI_PERIPHERAL_FRAME_ERR_EN to add the frame_err pulse output.
module spi_peripheral
    import spi_peripheral_pkg::*;
#(
    parameter int                                  TRANSACTION_LENGTH_BITS = 8,
    parameter logic [TRANSACTION_LENGTH_BITS-1:0] IDLE_WORD               = '0,
    parameter int                                  SYNC_STAGES             = 2
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               axiiv,
    input  logic [TRANSACTION_LENGTH_BITS-1:0] axiid,
    output logic                               axiready,
    output logic                               axiov,
    output logic [TRANSACTION_LENGTH_BITS-1:0] axiod,
`ifdef SPI_PERIPHERAL_FRAME_ERR_EN
    output logic                               frame_err,
`endif
    input  logic                               spi_cs_n,
    input  logic                               spi_clk,
    input  logic                               spi_din,
    output logic                               spi_dout
);

    localparam int N     = TRANSACTION_LENGTH_BITS;
    localparam int CNT_W = $clog2(N + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(N - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic cs_sync, sclk_sync, din_sync;
    logic cs_prev_reg, sclk_prev_reg;
    logic cs_fall, cs_rise, sclk_rise, sclk_fall;
    logic [SYNC_STAGES:0] settle_reg;
    logic settled;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic [N-1:0]     rx_shift_reg, rx_shift_next;
    logic [N-1:0]     tx_shift_reg, tx_shift_next;
    logic [N-1:0]     holding_reg, holding_next;
    logic             holding_valid_reg, holding_valid_next;
    logic [N-1:0]     axiod_reg, axiod_next;
    logic             axiov_reg, axiov_next;
`ifdef SPI_PERIPHERAL_FRAME_ERR_EN
    logic             frame_err_reg, frame_err_next;
`endif

    spi_sync_bit #(.STAGES(SYNC_STAGES), .RESET_VALUE(1'b1)) u_sync_cs (
        .clk(clk), .rst_n(rst_n), .d(spi_cs_n), .q(cs_sync)
    );
    spi_sync_bit #(.STAGES(SYNC_STAGES), .RESET_VALUE(1'b1)) u_sync_clk (
        .clk(clk), .rst_n(rst_n), .d(spi_clk), .q(sclk_sync)
    );
    spi_sync_bit #(.STAGES(SYNC_STAGES), .RESET_VALUE(1'b0)) u_sync_din (
        .clk(clk), .rst_n(rst_n), .d(spi_din), .q(din_sync)
    );

    assign cs_fall   =  cs_prev_reg   & ~cs_sync;
    assign cs_rise   = ~cs_prev_reg   &  cs_sync;
    assign sclk_rise = ~sclk_prev_reg &  sclk_sync;
    assign sclk_fall =  sclk_prev_reg & ~sclk_sync;

    // The synchronizers reset to "deselected"; only trust cs_n once real samples have filled them,
    // otherwise a reset taken with cs_n low would look like a deselect.
    assign settled = settle_reg[SYNC_STAGES];

    always_comb begin
        state_next         = state_reg;
        count_next         = count_reg;
        rx_shift_next      = rx_shift_reg;
        tx_shift_next      = tx_shift_reg;
        holding_next       = holding_reg;
        holding_valid_next = holding_valid_reg;
        axiod_next         = axiod_reg;
        axiov_next         = 1'b0;
`ifdef SPI_PERIPHERAL_FRAME_ERR_EN
        frame_err_next     = 1'b0;
`endif

        if (axiiv && !holding_valid_reg) begin
            holding_next       = axiid;
            holding_valid_next = 1'b1;
        end

        if (cs_sync) begin
            count_next = '0;
        end

        case (state_reg)
            WAIT_DESEL: begin
                if (settled && cs_sync) state_next = IDLE;
            end
            IDLE: begin
                if (cs_fall) begin
                    state_next    = SHIFT;
                    count_next    = '0;
                    rx_shift_next = '0;
                    if (holding_valid_reg) begin
                        tx_shift_next      = holding_reg;
                        holding_valid_next = 1'b0;
                    end else begin
                        tx_shift_next = IDLE_WORD;
                    end
                end
            end
            SHIFT: begin
                if (cs_rise) begin
                    state_next = IDLE;
                    count_next = '0;
`ifdef SPI_PERIPHERAL_FRAME_ERR_EN
                    frame_err_next = 1'b1;
`endif
                end else begin
                    if (sclk_rise) begin
                        rx_shift_next = {rx_shift_reg[N-2:0], din_sync};
                        count_next    = count_reg + CNT_ONE;
                        if (count_reg == LAST_BIT) begin
                            state_next = DONE;
                            axiod_next = {rx_shift_reg[N-2:0], din_sync};
                            axiov_next = 1'b1;
                        end
                    end
                    // The fall preceding the first rise presents bit N-1, which is already on MISO.
                    if (sclk_fall && count_reg != '0) begin
                        tx_shift_next = {tx_shift_reg[N-2:0], 1'b0};
                    end
                end
            end
            DONE: begin
                if (cs_rise) begin
                    state_next = IDLE;
                end
`ifdef SPI_PERIPHERAL_FRAME_ERR_EN
                else if (sclk_rise) begin
                    frame_err_next = 1'b1;
                end
`endif
            end
            default: state_next = WAIT_DESEL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_prev_reg       <= 1'b1;
            sclk_prev_reg     <= 1'b1;
            settle_reg        <= '0;
            state_reg         <= WAIT_DESEL;
            count_reg         <= '0;
            rx_shift_reg      <= '0;
            tx_shift_reg      <= '0;
            holding_reg       <= '0;
            holding_valid_reg <= 1'b0;
            axiod_reg         <= '0;
            axiov_reg         <= 1'b0;
`ifdef SPI_PERIPHERAL_FRAME_ERR_EN
            frame_err_reg     <= 1'b0;
`endif
        end else begin
            cs_prev_reg       <= cs_sync;
            sclk_prev_reg     <= sclk_sync;
            settle_reg        <= {settle_reg[SYNC_STAGES-1:0], 1'b1};
            state_reg         <= state_next;
            count_reg         <= count_next;
            rx_shift_reg      <= rx_shift_next;
            tx_shift_reg      <= tx_shift_next;
            holding_reg       <= holding_next;
            holding_valid_reg <= holding_valid_next;
            axiod_reg         <= axiod_next;
            axiov_reg         <= axiov_next;
`ifdef SPI_PERIPHERAL_FRAME_ERR_EN
            frame_err_reg     <= frame_err_next;
`endif
        end
    end

    assign axiready = ~holding_valid_reg;
    assign axiov    = axiov_reg;
    assign axiod    = axiod_reg;
    assign spi_dout = (!cs_sync && (state_reg == SHIFT || state_reg == DONE)) ? tx_shift_reg[N-1] : 1'b0;
`ifdef SPI_PERIPHERAL_FRAME_ERR_EN
    assign frame_err = frame_err_reg;
`endif

endmodule

// File: tb/tb_spi_peripheral.sv
// Directed bench for spi_peripheral: a mode-3 initiator model at 8 clk per SCLK period.
module tb_spi_peripheral;
    import spi_peripheral_pkg::*;

    localparam int N    = DEFAULT_WORD_BITS;
    localparam int HALF = 4;

    logic  clk      = 1'b0;
    logic  rst_n    = 1'b0;
    logic  axiiv    = 1'b0;
    word_t axiid    = '0;
    logic  axiready;
    logic  axiov;
    word_t axiod;
    logic  spi_cs_n = 1'b1;
    logic  spi_clk  = 1'b1;
    logic  spi_din  = 1'b0;
    logic  spi_dout;

    int vectors     = 0;
    int miscompares = 0;
    int pulse_cnt   = 0;

`ifdef SPI_PERIPHERAL_FRAME_ERR_EN
    logic frame_err;
    int   err_cnt = 0;
    always @(negedge clk) if (frame_err === 1'b1) err_cnt++;
`endif

    spi_peripheral #(
        .TRANSACTION_LENGTH_BITS(N),
        .IDLE_WORD('0),
        .SYNC_STAGES(2)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .axiiv(axiiv),
        .axiid(axiid),
        .axiready(axiready),
        .axiov(axiov),
        .axiod(axiod),
`ifdef SPI_PERIPHERAL_FRAME_ERR_EN
        .frame_err(frame_err),
`endif
        .spi_cs_n(spi_cs_n),
        .spi_clk(spi_clk),
        .spi_din(spi_din),
        .spi_dout(spi_dout)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (axiov === 1'b1) pulse_cnt++;

    // One SCLK period: fall with new MOSI, sample MISO just before the rise.
    task automatic spi_bit(input logic mosi, output logic miso);
        spi_clk = 1'b0;
        spi_din = mosi;
        repeat (HALF) @(negedge clk);
        miso    = spi_dout;
        spi_clk = 1'b1;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic spi_frame(input word_t mosi, input int nbits, input bit inject,
                             input word_t inj_word, output word_t miso);
        logic b;
        miso     = '0;
        spi_cs_n = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            if (i == 0 && inject) begin
                fork
                    spi_bit(mosi[N-1-i], b);
                    begin
                        // Lands on the cycle where the synchronized cs_n fall is seen.
                        @(negedge clk);
                        @(negedge clk);
                        axiiv = 1'b1;
                        axiid = inj_word;
                        @(negedge clk);
                        axiiv = 1'b0;
                    end
                join
            end else begin
                spi_bit(mosi[N-1-i], b);
            end
            miso = {miso[N-2:0], b};
        end
        spi_cs_n = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic queue_tx(input word_t w);
        int waited = 0;
        @(negedge clk);
        while (axiready !== 1'b1 && waited < 400) begin
            @(negedge clk);
            waited++;
        end
        vectors++;
        if (axiready !== 1'b1) begin
            miscompares++;
            $display("FAIL queue_timeout: axiready=%b required 1", axiready);
        end
        axiiv = 1'b1;
        axiid = w;
        @(negedge clk);
        axiiv = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        vectors += 4;
        if (axiov !== 1'b0)    begin miscompares++; $display("FAIL reset_axiov: got %b required 0", axiov); end
        if (axiod !== 8'h00)   begin miscompares++; $display("FAIL reset_axiod: got %h required 00", axiod); end
        if (axiready !== 1'b1) begin miscompares++; $display("FAIL reset_axiready: got %b required 1", axiready); end
        if (spi_dout !== 1'b0) begin miscompares++; $display("FAIL reset_dout: got %b required 0", spi_dout); end
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        $display("test_reset done");
    endtask

    task automatic test_loopback();
        word_t miso;
        int p0;
        queue_tx(8'hA5);
        vectors++;
        if (axiready !== 1'b0) begin miscompares++; $display("FAIL loop_ready_low: got %b required 0", axiready); end
        p0 = pulse_cnt;
        spi_frame(8'h3C, N, 1'b0, '0, miso);
        vectors += 4;
        if (miso !== 8'hA5)       begin miscompares++; $display("FAIL loop_miso: got %h required a5", miso); end
        if (axiod !== 8'h3C)      begin miscompares++; $display("FAIL loop_axiod: got %h required 3c", axiod); end
        if (pulse_cnt - p0 != 1)  begin miscompares++; $display("FAIL loop_pulses: got %0d required 1", pulse_cnt - p0); end
        if (axiready !== 1'b1)    begin miscompares++; $display("FAIL loop_ready_back: got %b required 1", axiready); end
        $display("test_loopback: mosi 3c miso %h axiod %h", miso, axiod);
    endtask

    task automatic test_idle_word();
        word_t miso;
        int p0 = pulse_cnt;
        spi_frame(8'hFF, N, 1'b0, '0, miso);
        vectors += 3;
        if (miso !== 8'h00)      begin miscompares++; $display("FAIL idle_miso: got %h required 00", miso); end
        if (axiod !== 8'hFF)     begin miscompares++; $display("FAIL idle_axiod: got %h required ff", axiod); end
        if (pulse_cnt - p0 != 1) begin miscompares++; $display("FAIL idle_pulses: got %0d required 1", pulse_cnt - p0); end
        $display("test_idle_word: mosi ff miso %h axiod %h", miso, axiod);
    endtask

    task automatic test_back_to_back();
        word_t miso1, miso2;
        word_t rx1;
        int p0;
        queue_tx(8'h11);
        p0 = pulse_cnt;
        fork
            spi_frame(8'h01, N, 1'b0, '0, miso1);
            queue_tx(8'h22);
        join
        rx1 = axiod;
        spi_frame(8'h02, N, 1'b0, '0, miso2);
        vectors += 5;
        if (miso1 !== 8'h11)     begin miscompares++; $display("FAIL b2b_miso1: got %h required 11", miso1); end
        if (rx1 !== 8'h01)       begin miscompares++; $display("FAIL b2b_axiod1: got %h required 01", rx1); end
        if (miso2 !== 8'h22)     begin miscompares++; $display("FAIL b2b_miso2: got %h required 22", miso2); end
        if (axiod !== 8'h02)     begin miscompares++; $display("FAIL b2b_axiod2: got %h required 02", axiod); end
        if (pulse_cnt - p0 != 2) begin miscompares++; $display("FAIL b2b_pulses: got %0d required 2", pulse_cnt - p0); end
        $display("test_back_to_back: miso %h %h axiod %h", miso1, miso2, axiod);
    endtask

    task automatic test_abort();
        word_t miso;
        int p0 = pulse_cnt;
`ifdef SPI_PERIPHERAL_FRAME_ERR_EN
        int e0 = err_cnt;
`endif
        spi_frame(8'hC3, 4, 1'b0, '0, miso);
        vectors += 2;
        if (pulse_cnt != p0)  begin miscompares++; $display("FAIL abort_pulses: got %0d required 0", pulse_cnt - p0); end
        if (axiod !== 8'h02)  begin miscompares++; $display("FAIL abort_axiod: got %h required 02", axiod); end
`ifdef SPI_PERIPHERAL_FRAME_ERR_EN
        vectors++;
        if (err_cnt - e0 != 1) begin miscompares++; $display("FAIL abort_frame_err: got %0d required 1", err_cnt - e0); end
`endif
        spi_frame(8'h5A, N, 1'b0, '0, miso);
        vectors += 3;
        if (axiod !== 8'h5A)     begin miscompares++; $display("FAIL abort_next_axiod: got %h required 5a", axiod); end
        if (miso !== 8'h00)      begin miscompares++; $display("FAIL abort_next_miso: got %h required 00", miso); end
        if (pulse_cnt - p0 != 1) begin miscompares++; $display("FAIL abort_next_pulses: got %0d required 1", pulse_cnt - p0); end
        $display("test_abort: after abort axiod %h", axiod);
    endtask

    task automatic test_reset_midframe();
        word_t miso;
        logic  b;
        logic  dout_seen = 1'b0;
        int    p0;
        spi_cs_n = 1'b0;
        for (int i = 0; i < 3; i++) spi_bit(1'b1, b);
        queue_tx(8'h77);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        vectors += 4;
        if (axiov !== 1'b0)    begin miscompares++; $display("FAIL rstmid_axiov: got %b required 0", axiov); end
        if (axiod !== 8'h00)   begin miscompares++; $display("FAIL rstmid_axiod: got %h required 00", axiod); end
        if (axiready !== 1'b1) begin miscompares++; $display("FAIL rstmid_axiready: got %b required 1", axiready); end
        if (spi_dout !== 1'b0) begin miscompares++; $display("FAIL rstmid_dout: got %b required 0", spi_dout); end
        rst_n = 1'b1;
        p0 = pulse_cnt;
        for (int i = 0; i < 5; i++) begin
            spi_bit(1'b1, b);
            if (b !== 1'b0) dout_seen = 1'b1;
        end
        vectors += 3;
        if (dout_seen !== 1'b0) begin miscompares++; $display("FAIL rstmid_tail_dout: got %b required 0", dout_seen); end
        if (pulse_cnt != p0)    begin miscompares++; $display("FAIL rstmid_tail_pulses: got %0d required 0", pulse_cnt - p0); end
        if (axiod !== 8'h00)    begin miscompares++; $display("FAIL rstmid_tail_axiod: got %h required 00", axiod); end
        spi_cs_n = 1'b1;
        repeat (10) @(negedge clk);
        spi_frame(8'h96, N, 1'b0, '0, miso);
        vectors += 3;
        if (axiod !== 8'h96)     begin miscompares++; $display("FAIL rstmid_next_axiod: got %h required 96", axiod); end
        if (miso !== 8'h00)      begin miscompares++; $display("FAIL rstmid_next_miso: got %h required 00", miso); end
        if (pulse_cnt - p0 != 1) begin miscompares++; $display("FAIL rstmid_next_pulses: got %0d required 1", pulse_cnt - p0); end
        $display("test_reset_midframe: next frame axiod %h miso %h", axiod, miso);
    endtask

    task automatic test_same_cycle();
        word_t miso1, miso2;
        vectors++;
        if (axiready !== 1'b1) begin miscompares++; $display("FAIL same_pre_ready: got %b required 1", axiready); end
        spi_frame(8'h0F, N, 1'b1, 8'hE7, miso1);
        vectors += 3;
        if (miso1 !== 8'h00)   begin miscompares++; $display("FAIL same_miso1: got %h required 00", miso1); end
        if (axiready !== 1'b0) begin miscompares++; $display("FAIL same_held: got %b required 0", axiready); end
        if (axiod !== 8'h0F)   begin miscompares++; $display("FAIL same_axiod1: got %h required 0f", axiod); end
        spi_frame(8'hF0, N, 1'b0, '0, miso2);
        vectors += 2;
        if (miso2 !== 8'hE7)   begin miscompares++; $display("FAIL same_miso2: got %h required e7", miso2); end
        if (axiod !== 8'hF0)   begin miscompares++; $display("FAIL same_axiod2: got %h required f0", axiod); end
        $display("test_same_cycle: miso %h then %h", miso1, miso2);
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_loopback();
        test_idle_word();
        test_back_to_back();
        test_abort();
        test_reset_midframe();
        test_same_cycle();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
